// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: zero-wait hits, whole-line fill on miss, global flush.
// Latency: hit 0 cycles; miss stalls 1 + memory cycles + 1 (UPDATE), backpressure via busywait/mem_busywait.
module icache_direct_mapped #(
  parameter int NUM_LINES  = 8,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 25
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [31:0]  address,
  input  logic         flush,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [27:0]          mem_address_q, mem_address_d;
  logic [15:0]          hit_count_q, hit_count_d;
  logic [15:0]          miss_count_q, miss_count_d;

  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [127:0]         data_mem [NUM_LINES];

  logic [INDEX_BITS-1:0] cpu_idx, fill_idx;
  logic [TAG_BITS-1:0]   cpu_tag, fill_tag;
  logic [127:0]          cpu_line;
  logic                  hit;
  logic                  install;
  logic                  unused_addr_bits;

  assign cpu_idx          = address[3+INDEX_BITS:4];
  assign cpu_tag          = address[31:4+INDEX_BITS];
  assign fill_idx         = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag         = mem_address_q[27:INDEX_BITS];
  assign unused_addr_bits = ^address[1:0];

  assign cpu_line    = data_mem[cpu_idx];
  assign hit         = read & valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
  assign instruction = hit ? cpu_line[{address[3:2], 5'b0} +: 32] : 32'h0;

  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = mem_address_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  // Stall is gated by reset so the CPU is never held while the cache is in reset.
  always_comb begin
    busywait = 1'b1;
    if (state_q == IDLE) busywait = read & ~hit;
    if (!reset) busywait = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    mem_address_d = mem_address_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    install       = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
        if (read && !hit && !flush) begin
          state_d       = MEM_READ;
          mem_address_d = address[31:4];
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        install           = 1'b1;
        valid_d[fill_idx] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over a same-edge install: data lands but the line stays invalid.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      mem_address_q <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      mem_address_q <= mem_address_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (install) begin
      data_mem[fill_idx] <= mem_readdata;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: behavioural line memory with fixed busy latency and an instruction scoreboard.
module tb_icache_direct_mapped;

  localparam int LAT = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [31:0]  address;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int mem_cnt;
  logic [127:0] mem [256];
  logic [31:0]  exp_q [$];

  icache_direct_mapped #(.NUM_LINES(8), .INDEX_BITS(3), .TAG_BITS(25)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address), .flush(flush),
    .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Memory stays busy for LAT edges after the request, then presents the line.
  assign mem_busywait = mem_read && (mem_cnt < LAT);
  assign mem_readdata = mem[mem_address[7:0]];

  always @(posedge clock or negedge reset) begin
    if (!reset) mem_cnt <= 0;
    else if (!mem_read) mem_cnt <= 0;
    else if (mem_busywait) mem_cnt <= mem_cnt + 1;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = mem[a[11:4]];
    return l[{a[3:2], 5'b0} +: 32];
  endfunction

  task automatic check_counts(input string tag);
    int eh, em;
    eh = (exp_hits > 65535) ? 65535 : exp_hits;
    em = (exp_misses > 65535) ? 65535 : exp_misses;
    checks++;
    if (hit_count !== eh[15:0]) begin
      errors++;
      $display("FAIL %s hit_count: got %0d expected %0d", tag, hit_count, eh);
    end
    checks++;
    if (miss_count !== em[15:0]) begin
      errors++;
      $display("FAIL %s miss_count: got %0d expected %0d", tag, miss_count, em);
    end
  endtask

  // One complete fetch: drive, wait out the stall, compare against the scoreboard.
  task automatic fetch(input logic [31:0] a, input bit exp_miss, input bit flush_upd);
    int  n;
    int  exp_busy;
    bit  seen_mr;
    bit  flushed;
    logic [31:0] exp;
    exp_q.push_back(word_of(a));
    @(posedge clock); #1;
    read = 1'b1;
    address = a;
    n = 0; seen_mr = 0; flushed = 0;
    @(negedge clock);
    if (busywait) begin
      checks++;
      if (instruction !== 32'h0) begin
        errors++;
        $display("FAIL miss_instr_zero @%h: got %h expected 0", a, instruction);
      end
    end
    while (busywait && n < 200) begin
      if (mem_read && !seen_mr) begin
        seen_mr = 1;
        checks++;
        if (mem_address !== a[31:4]) begin
          errors++;
          $display("FAIL mem_address @%h: got %h expected %h", a, mem_address, a[31:4]);
        end
      end
      if (flush_upd && seen_mr && !mem_read && !flushed) begin
        flushed = 1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
      end
      n++;
      @(negedge clock);
    end
    exp_busy = !exp_miss ? 0 : (flush_upd ? 2 * (LAT + 3) : LAT + 3);
    checks++;
    if (n !== exp_busy) begin
      errors++;
      $display("FAIL busy_cycles @%h: got %0d expected %0d", a, n, exp_busy);
    end
    exp = exp_q.pop_front();
    checks++;
    if (instruction !== exp) begin
      errors++;
      $display("FAIL instruction @%h: got %h expected %h", a, instruction, exp);
    end
    @(posedge clock); #1;
    read = 1'b0;
    exp_hits++;
    if (exp_miss) exp_misses += flush_upd ? 2 : 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; read = 1'b1; address = 32'h0; flush = 1'b0;
    #3;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0 || mem_address !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got bw=%b mr=%b ins=%h ma=%h expected 0/0/0/0",
               busywait, mem_read, instruction, mem_address);
    end
    check_counts("reset");
    read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0000, 1, 0);
    checks++;
    if (word_of(32'h0) !== 32'hc180_0013) begin
      errors++;
      $display("FAIL cold_model: got %h expected c1800013", word_of(32'h0));
    end
    check_counts("cold_miss");
  endtask

  task automatic test_same_line_hits();
    fetch(32'h0000_0004, 0, 0);
    fetch(32'h0000_0008, 0, 0);
    check_counts("same_line");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      read = 1'b1;
      address = 32'(i * 4);
      exp_q.push_back(word_of(address));
      @(negedge clock);
      exp = exp_q.pop_front();
      checks++;
      if (busywait !== 1'b0 || instruction !== exp) begin
        errors++;
        $display("FAIL b2b[%0d]: got bw=%b ins=%h expected bw=0 ins=%h", i, busywait, instruction, exp);
      end
    end
    @(posedge clock); #1;
    read = 1'b0;
    exp_hits += 4;
    check_counts("back_to_back");
  endtask

  task automatic test_addr_change();
    int n;
    logic [31:0] exp;
    exp_q.push_back(32'h0000_a2a3);
    @(posedge clock); #1;
    read = 1'b1;
    address = 32'h10;
    n = 0;
    @(negedge clock);
    while (!mem_read && n < 50) begin n++; @(negedge clock); end
    address = 32'h20;
    while (mem_read && n < 100) begin
      checks++;
      if (mem_address !== 28'h1) begin
        errors++;
        $display("FAIL held_mem_address: got %h expected 0000001", mem_address);
      end
      n++;
      @(negedge clock);
    end
    address = 32'h10;
    @(negedge clock);
    exp = exp_q.pop_front();
    checks++;
    if (busywait !== 1'b0 || instruction !== exp) begin
      errors++;
      $display("FAIL addr_change_fill: got bw=%b ins=%h expected bw=0 ins=%h", busywait, instruction, exp);
    end
    @(posedge clock); #1;
    read = 1'b0;
    exp_hits++;
    exp_misses++;
    fetch(32'h20, 1, 0);
    check_counts("addr_change");
  endtask

  task automatic test_conflict();
    fetch(32'h80, 1, 0);
    fetch(32'h00, 1, 0);
    fetch(32'h04, 0, 0);
    check_counts("conflict");
  endtask

  task automatic test_flush();
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    fetch(32'h0, 1, 0);
    @(posedge clock); #1;
    read = 1'b1; address = 32'h30; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL flush_suppress: got mem_read=%b expected 0", mem_read);
    end
    read = 1'b0;
    fetch(32'h30, 1, 1);
    fetch(32'h34, 0, 0);
    check_counts("flush");
  endtask

  task automatic test_reset_mid_fill();
    int n;
    @(posedge clock); #1;
    read = 1'b1;
    address = 32'h40;
    n = 0;
    @(negedge clock);
    while (!mem_read && n < 50) begin n++; @(negedge clock); end
    reset = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    checks++;
    if (mem_read !== 1'b0 || busywait !== 1'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_fill: got mr=%b bw=%b ins=%h expected 0/0/0", mem_read, busywait, instruction);
    end
    check_counts("reset_mid_fill");
    read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    fetch(32'h40, 1, 0);
    check_counts("after_reset");
  endtask

  task automatic test_saturation();
    @(posedge clock); #1;
    read = 1'b1;
    address = 32'h44;
    repeat (65540) @(posedge clock);
    #1;
    exp_hits += 65540;
    check_counts("saturation");
    read = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {32'hA300_0000 | (i << 8), 32'hA200_0000 | (i << 8),
                32'hA100_0000 | (i << 8), 32'hA000_0000 | (i << 8)};
    mem[0] = 128'h00000000_00000000_00208093_c1800013;
    mem[1] = 128'h11111111_22222222_33333333_0000a2a3;
    mem[2] = 128'h44444444_55555555_66666666_0050a103;

    test_reset();
    test_cold_miss();
    test_same_line_hits();
    test_back_to_back();
    test_addr_change();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
